mc_controller: RTL
==================

# mc_controller

Main control FSM for the multicycle RV32I core. It sequences the shared ALU, register file, instruction register and unified memory port across fetch, decode, execute, memory and writeback states, driving the ALU operand muxes and the 2-bit ALUOp consumed by the ALU decoder. The controller sits beside the datapath: it takes opcode, zero flag and memory handshake in and produces every enable and select out.

## Interface
- No parameters; state encoding and opcode values come from the shared package.
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- op  in  7  instr[6:0], opcode from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable = PCUpdate | (Branch & zero)
- AdrSrc  out  1  0 = PC, 1 = ALUOut drives memory address
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 data
- ALUSrcB  out  2  00 rs2 data, 01 ImmExt, 10 constant 4
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
- RegWrite  out  1  register file write
- illegal_op  out  1  one-cycle pulse, unsupported opcode in DECODE
- retire  out  1  one-cycle pulse in an instruction's final state

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Outputs are a Moore decode of state, except PCWrite (uses zero) and the memory gating below. Unlisted outputs are 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, which computes the branch/jump target.
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other opcode → FETCH, with illegal_op=1
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD if op=0000011, otherwise MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1. Next state FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, retire=1. Next state FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1. Next state FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, retire=1. Next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state ALUWB, which retires the instruction.
- Illegal opcode is not retired; the core refetches at PC+4.

## Timing
- Reset is synchronous. While reset=1, state is loaded to FETCH at each edge.
- During reset, PCWrite, IRWrite, RegWrite, MemWrite, illegal_op and retire are forced to 0. All other outputs show FETCH values.
- Reset asserted mid-instruction abandons that instruction. No write enable is asserted in the reset cycle.
- First fetch is in the cycle after reset deasserts.
- Cycles per instruction with mem_ready always 1:
  - lw 5, sw 4
  - R-type 4, I-type 4
  - beq 3, jal 4
- Latency from the FETCH cycle to the retire pulse equals that count.

## Configuration
- MC_CTRL_MEM_WAIT_EN defined:
  - FETCH, MEMREAD and MEMWRITE hold their state until mem_ready=1.
  - In FETCH, IRWrite and PCWrite are asserted only when mem_ready=1.
  - In MEMWRITE, MemWrite stays high while waiting; retire fires only in the mem_ready cycle.
  - ALU selects stay stable during the wait.
- MC_CTRL_MEM_WAIT_EN undefined: mem_ready is ignored and every memory state lasts exactly one cycle.

## Structure
- Shared package `mc_pkg`:
  - state enum typedef
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - ALUOp constants
  - ResultSrc, ALUSrcA and ALUSrcB encodings, so the datapath muxes share them
- Sub-module `mc_ctrl_outdec`: combinational state→control-vector decode. The top level holds the state register, next-state logic, PCWrite and the wait gating.

## Test plan
- Reset hold for 3 cycles:
  - all write enables are 0 during reset
  - IRWrite=1 and ALUSrcB=10 in the first post-reset cycle
- Sequence lw, sw, add, addi, beq, jal with mem_ready=1:
  - state traces match the Operation section
  - retire pulses at cycles 5, 9, 13, 17, 20, 24
- beq with zero=1 → PCWrite=1 in the BEQ cycle; with zero=0 → PCWrite=0 in the BEQ cycle.
- Opcode 0000000 → illegal_op pulses once in DECODE, next state FETCH, no retire pulse.
- With MC_CTRL_MEM_WAIT_EN and mem_ready low for 3 cycles in FETCH and in MEMREAD:
  - IRWrite stays 0 until the mem_ready cycle
  - lw takes 11 cycles
- Reset asserted in MEMWRITE → MemWrite=0 in the reset cycle, state returns to FETCH, no retire pulse.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I control FSM and its datapath muxes.
package mc_pkg;

    localparam int unsigned STATE_W = 4;

    localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
    localparam logic [STATE_W-1:0] S_MEMADR   = 4'd2;
    localparam logic [STATE_W-1:0] S_MEMREAD  = 4'd3;
    localparam logic [STATE_W-1:0] S_MEMWB    = 4'd4;
    localparam logic [STATE_W-1:0] S_MEMWRITE = 4'd5;
    localparam logic [STATE_W-1:0] S_EXECUTER = 4'd6;
    localparam logic [STATE_W-1:0] S_EXECUTEI = 4'd7;
    localparam logic [STATE_W-1:0] S_ALUWB    = 4'd8;
    localparam logic [STATE_W-1:0] S_BEQ      = 4'd9;
    localparam logic [STATE_W-1:0] S_JAL      = 4'd10;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = S_FETCH,
        DECODE   = S_DECODE,
        MEMADR   = S_MEMADR,
        MEMREAD  = S_MEMREAD,
        MEMWB    = S_MEMWB,
        MEMWRITE = S_MEMWRITE,
        EXECUTER = S_EXECUTER,
        EXECUTEI = S_EXECUTEI,
        ALUWB    = S_ALUWB,
        BEQ      = S_BEQ,
        JAL      = S_JAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Raw per-state control vector before reset, zero and handshake gating.
    typedef struct packed {
        logic       pcupdate;
        logic       branch;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       retire;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore decode of FSM state into the raw control vector.
module mc_ctrl_outdec
    import mc_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.irwrite   = 1'b1;
                ctrl.pcupdate  = 1'b1;
                ctrl.alusrca   = SRCA_PC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.aluop     = ALUOP_ADD;
                ctrl.resultsrc = RES_ALURESULT;
            end
            DECODE: begin
                ctrl.alusrca = SRCA_OLDPC;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alusrca = SRCA_RS1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMREAD: begin
                ctrl.adrsrc    = 1'b1;
                ctrl.resultsrc = RES_ALUOUT;
            end
            MEMWB: begin
                ctrl.resultsrc = RES_DATA;
                ctrl.regwrite  = 1'b1;
                ctrl.retire    = 1'b1;
            end
            MEMWRITE: begin
                ctrl.adrsrc    = 1'b1;
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.memwrite  = 1'b1;
                ctrl.retire    = 1'b1;
            end
            EXECUTER: begin
                ctrl.alusrca = SRCA_RS1;
                ctrl.alusrcb = SRCB_RS2;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                ctrl.alusrca = SRCA_RS1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.regwrite  = 1'b1;
                ctrl.retire    = 1'b1;
            end
            BEQ: begin
                ctrl.alusrca   = SRCA_RS1;
                ctrl.alusrcb   = SRCB_RS2;
                ctrl.aluop     = ALUOP_SUB;
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.branch    = 1'b1;
                ctrl.retire    = 1'b1;
            end
            JAL: begin
                ctrl.alusrca   = SRCA_OLDPC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.aluop     = ALUOP_ADD;
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.pcupdate  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Main control FSM of the multicycle RV32I core.
// Optional MC_CTRL_MEM_WAIT_EN: FETCH/MEMREAD/MEMWRITE stall until mem_ready.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic       retire
);

    state_t state;
    state_t state_nxt;
    state_t dec_state;
    ctrl_t  ctrl;
    logic   mem_go;
    logic   op_legal;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    logic unused_mem_ready;
    assign mem_go           = 1'b1;
    assign unused_mem_ready = mem_ready;
`endif

    // Reset presents FETCH selects regardless of the abandoned state.
    assign dec_state = reset ? FETCH : state;

    assign op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                      (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);

    mc_ctrl_outdec u_outdec (
        .state (dec_state),
        .ctrl  (ctrl)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        illegal_op = 1'b0;
        retire     = 1'b0;
        AdrSrc     = ctrl.adrsrc;
        ResultSrc  = ctrl.resultsrc;
        ALUSrcA    = ctrl.alusrca;
        ALUSrcB    = ctrl.alusrcb;
        ALUOp      = ctrl.aluop;

        case (state)
            FETCH:    if (mem_go) state_nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_R:         state_nxt = EXECUTER;
                    OP_I:         state_nxt = EXECUTEI;
                    OP_BEQ:       state_nxt = BEQ;
                    OP_JAL:       state_nxt = JAL;
                    default:      state_nxt = FETCH;
                endcase
            end
            MEMADR:   state_nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (mem_go) state_nxt = MEMWB;
            MEMWB:    state_nxt = FETCH;
            MEMWRITE: if (mem_go) state_nxt = FETCH;
            EXECUTER: state_nxt = ALUWB;
            EXECUTEI: state_nxt = ALUWB;
            ALUWB:    state_nxt = FETCH;
            BEQ:      state_nxt = FETCH;
            JAL:      state_nxt = ALUWB;
            default:  state_nxt = FETCH;
        endcase

        // Write enables are suppressed for the whole reset cycle.
        if (!reset) begin
            IRWrite    = ctrl.irwrite & mem_go;
            PCWrite    = (ctrl.pcupdate & ((state != FETCH) | mem_go)) |
                         (ctrl.branch & zero);
            MemWrite   = ctrl.memwrite;
            RegWrite   = ctrl.regwrite;
            retire     = ctrl.retire & ((state != MEMWRITE) | mem_go);
            illegal_op = (state == DECODE) & ~op_legal;
        end
    end

endmodule
